// File: rtl/axis_mem_arbiter.sv
// Two-port AXI-Stream arbiter feeding a single registered memory write stream.
// Round-robin between requesters with the grant locked for a whole packet.
module axis_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                      axis_aclk,
    input  logic                      axis_aresetn,

    input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s01_axis_tstrb,
    input  logic                      s01_axis_tvalid,
    input  logic                      s01_axis_tlast,
    output logic                      s01_axis_tready,

    input  logic [DATA_WIDTH-1:0]     s02_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s02_axis_tstrb,
    input  logic                      s02_axis_tvalid,
    input  logic                      s02_axis_tlast,
    output logic                      s02_axis_tready,

    output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
    output logic                      m01_axis_tvalid,
    output logic                      m01_axis_tlast,
    input  logic                      m01_axis_tready,

    output logic [1:0]                grant,
    output logic [CNT_WIDTH-1:0]      pkt_cnt0,
    output logic [CNT_WIDTH-1:0]      pkt_cnt1
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e state_q, state_d;
    // last_gnt: 0 = s01 owned the previous packet, 1 = s02 did
    logic   last_gnt_q, last_gnt_d;
    logic   free;
    logic   acc0, acc1;

    assign free = !m01_axis_tvalid || m01_axis_tready;
    assign acc0 = (state_q == StGnt0) && s01_axis_tvalid && free;
    assign acc1 = (state_q == StGnt1) && s02_axis_tvalid && free;

    assign s01_axis_tready = (state_q == StGnt0) && free;
    assign s02_axis_tready = (state_q == StGnt1) && free;
    assign grant           = {state_q == StGnt1, state_q == StGnt0};

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            StIdle: begin
                if (s01_axis_tvalid && s02_axis_tvalid) begin
                    state_d = last_gnt_q ? StGnt0 : StGnt1;
                end else if (s01_axis_tvalid) begin
                    state_d = StGnt0;
                end else if (s02_axis_tvalid) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (acc0 && s01_axis_tlast) begin
                    state_d    = StIdle;
                    last_gnt_d = 1'b0;
                end
            end
            StGnt1: begin
                if (acc1 && s02_axis_tlast) begin
                    state_d    = StIdle;
                    last_gnt_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Output register: load on an accepted beat, hold under back-pressure
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m01_axis_tdata  <= '0;
            m01_axis_tstrb  <= '0;
            m01_axis_tvalid <= 1'b0;
            m01_axis_tlast  <= 1'b0;
        end else if (acc0) begin
            m01_axis_tdata  <= s01_axis_tdata;
            m01_axis_tstrb  <= s01_axis_tstrb;
            m01_axis_tvalid <= 1'b1;
            m01_axis_tlast  <= s01_axis_tlast;
        end else if (acc1) begin
            m01_axis_tdata  <= s02_axis_tdata;
            m01_axis_tstrb  <= s02_axis_tstrb;
            m01_axis_tvalid <= 1'b1;
            m01_axis_tlast  <= s02_axis_tlast;
        end else if (free) begin
            m01_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (acc0 && s01_axis_tlast) pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
            if (acc1 && s02_axis_tlast) pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axis_mem_arbiter.sv
// Scoreboard bench for axis_mem_arbiter: directed packets, expected beats queued
// up front, a negedge monitor pops and compares every output handshake.
module tb_axis_mem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s01_tdata, s02_tdata, m01_tdata;
    logic [3:0]    s01_tstrb, s02_tstrb, m01_tstrb;
    logic          s01_tvalid, s01_tlast, s01_tready;
    logic          s02_tvalid, s02_tlast, s02_tready;
    logic          m01_tvalid, m01_tlast, m01_tready;
    logic [1:0]    grant;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;

    int checks = 0;
    int errors = 0;
    logic [36:0] sb[$];   // {last, strb, data}

    axis_mem_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .axis_aclk      (clk),
        .axis_aresetn   (rst_n),
        .s01_axis_tdata (s01_tdata),
        .s01_axis_tstrb (s01_tstrb),
        .s01_axis_tvalid(s01_tvalid),
        .s01_axis_tlast (s01_tlast),
        .s01_axis_tready(s01_tready),
        .s02_axis_tdata (s02_tdata),
        .s02_axis_tstrb (s02_tstrb),
        .s02_axis_tvalid(s02_tvalid),
        .s02_axis_tlast (s02_tlast),
        .s02_axis_tready(s02_tready),
        .m01_axis_tdata (m01_tdata),
        .m01_axis_tstrb (m01_tstrb),
        .m01_axis_tvalid(m01_tvalid),
        .m01_axis_tlast (m01_tlast),
        .m01_axis_tready(m01_tready),
        .grant          (grant),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic l);
        sb.push_back({l, 4'hF, d});
    endtask

    always @(negedge clk) begin
        if (rst_n && m01_tvalid && m01_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got beat 0x%0h, required no beat", m01_tdata);
            end else begin
                check("sb_beat", {m01_tlast, m01_tstrb, m01_tdata[26:0]},
                      {sb[0][36], sb[0][35:32], sb[0][26:0]});
                check("sb_data", m01_tdata, sb[0][31:0]);
                void'(sb.pop_front());
            end
        end
    end

    // Present one beat (caller aligned #1 after a posedge); returns #1 after acceptance
    task automatic drive_beat(input int p, input logic [31:0] d, input logic l);
        bit acc = 0;
        if (p == 0) begin
            s01_tdata = d; s01_tstrb = 4'hF; s01_tlast = l; s01_tvalid = 1'b1;
        end else begin
            s02_tdata = d; s02_tstrb = 4'hF; s02_tlast = l; s02_tvalid = 1'b1;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((p == 0) ? s01_tready : s02_tready) begin
                acc = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: port %0d beat 0x%0h not accepted, required accept", p, d);
        end
    endtask

    task automatic send_pkt(input int p, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) drive_beat(p, base + i, (i == n - 1));
        if (p == 0) s01_tvalid = 1'b0;
        else        s02_tvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        m01_tready = 1'b1;
        s01_tvalid = 0; s01_tlast = 0; s01_tdata = '0; s01_tstrb = '0;
        s02_tvalid = 0; s02_tlast = 0; s02_tdata = '0; s02_tstrb = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_tvalid", 32'(m01_tvalid), 0);
        check("rst_tlast", 32'(m01_tlast), 0);
        check("rst_tdata", m01_tdata, 0);
        check("rst_tstrb", 32'(m01_tstrb), 0);
        check("rst_cnt0", 32'(pkt_cnt0), 0);
        check("rst_cnt1", 32'(pkt_cnt1), 0);
        check("rst_treadys", {30'd0, s01_tready, s02_tready}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 4-beat s01 packet
        for (int i = 0; i < 4; i++) expect_beat(32'h11 + i, i == 3);
        s01_tvalid = 1'b1; s01_tdata = 32'h11; s01_tstrb = 4'hF;
        @(negedge clk);
        check("idle_no_ready", 32'(s01_tready), 0);
        @(posedge clk); #1;
        send_pkt(0, 32'h11, 4);
        check("t1_grant_idle", 32'(grant), 0);
        check("t1_cnt0", 32'(pkt_cnt0), 1);
        repeat (3) @(posedge clk); #1;

        // simultaneous requests after reset: s01 wins the tie
        rst_n = 1'b0; #2 rst_n = 1'b1;
        @(posedge clk); #1;
        expect_beat(32'hA0, 0); expect_beat(32'hA1, 1);
        expect_beat(32'hB0, 0); expect_beat(32'hB1, 1);
        fork
            send_pkt(0, 32'hA0, 2);
            send_pkt(1, 32'hB0, 2);
        join
        check("t2_cnt0", 32'(pkt_cnt0), 1);
        check("t2_cnt1", 32'(pkt_cnt1), 1);
        repeat (3) @(posedge clk); #1;

        // continuous single-beat requests alternate
        for (int k = 0; k < 3; k++) begin
            expect_beat(32'hC1 + k, 1);
            expect_beat(32'hD1 + k, 1);
        end
        fork
            for (int k = 0; k < 3; k++) send_pkt(0, 32'hC1 + k, 1);
            for (int k = 0; k < 3; k++) send_pkt(1, 32'hD1 + k, 1);
        join
        check("t3_cnt0", 32'(pkt_cnt0), 4);
        check("t3_cnt1", 32'(pkt_cnt1), 4);
        repeat (3) @(posedge clk); #1;

        // back-pressure at beat 2, s02 requesting mid-packet
        for (int i = 0; i < 4; i++) expect_beat(32'hE0 + i, i == 3);
        expect_beat(32'hF0, 1);
        fork
            send_pkt(0, 32'hE0, 4);
            begin
                repeat (2) @(posedge clk); #1;
                send_pkt(1, 32'hF0, 1);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (m01_tvalid && m01_tdata == 32'hE0) break;
                end
                @(posedge clk); #1;
                m01_tready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_data", m01_tdata, 32'hE1);
                    check("stall_valid", 32'(m01_tvalid), 1);
                    check("stall_s01_ready", 32'(s01_tready), 0);
                    check("stall_grant", 32'(grant), 32'b01);
                end
                @(posedge clk); #1;
                m01_tready = 1'b1;
            end
        join
        check("t4_cnt0", 32'(pkt_cnt0), 5);
        check("t4_cnt1", 32'(pkt_cnt1), 5);
        repeat (3) @(posedge clk); #1;

        // reset mid-packet on s02
        expect_beat(32'h50, 0);
        drive_beat(1, 32'h50, 0);
        drive_beat(1, 32'h51, 0);
        rst_n = 1'b0;
        s02_tvalid = 1'b0;
        #1;
        check("t5_rst_tvalid", 32'(m01_tvalid), 0);
        check("t5_rst_cnt1", 32'(pkt_cnt1), 0);
        check("t5_rst_cnt0", 32'(pkt_cnt0), 0);
        check("t5_rst_grant", 32'(grant), 0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        expect_beat(32'h60, 0); expect_beat(32'h61, 1);
        send_pkt(0, 32'h60, 2);
        check("t5_cnt0", 32'(pkt_cnt0), 1);
        repeat (3) @(posedge clk); #1;

        // counter wrap: 17 single-beat packets on s02
        for (int k = 0; k < 17; k++) expect_beat(32'h700 + k, 1);
        for (int k = 0; k < 17; k++) send_pkt(1, 32'h700 + k, 1);
        repeat (2) @(posedge clk); #1;
        check("t6_cnt1_wrap", 32'(pkt_cnt1), 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
